// File: rtl/imem_fetch_arbiter_if.sv
// ----------------------------------------------------------------------------
// imem_fetch_arbiter_if
// Bundles the three buses around the instruction-memory arbiter:
//   fetch_*  : PC/fetch stage request and the assembled 32-bit instruction
//   ld_*     : boot-loader byte write request and acknowledge
//   mem_*    : the single byte-wide memory port (combinational read data)
// Modports:
//   slave  : the arbiter's view (requests and read data in, grants and bus out)
//   master : the environment's view (fetch stage + loader + memory array)
// ----------------------------------------------------------------------------
interface imem_fetch_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              fetch_err;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
        output fetch_ready, fetch_valid, fetch_instr, fetch_err,
               ld_ack, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_err,
               ld_ack, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// imem_fetch_arbiter
// Shares one byte-wide instruction-memory port between the fetch path and the
// program loader. A fetch reads four consecutive bytes and returns them as a
// big-endian 32-bit word; a loader request writes one byte in a single IDLE
// cycle. Simultaneous requests are arbitrated round-robin.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; gates mem_we/ld_ack and all outputs low
//   bus    : imem_fetch_arbiter_if.slave (fetch, loader and memory buses)
// Parameters:
//   ADDR_W      : memory byte-address width
//   ALIGN_CHECK : 1 = fetch address with [1:0]!=0 returns a fault
// ----------------------------------------------------------------------------
module imem_fetch_arbiter #(
    parameter int ADDR_W      = 8,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_fetch_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_RESP} state_t;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_LOAD  = 1'b1;

    state_t            r_state, w_state_next;
    logic [1:0]        r_cnt, w_cnt_next;
    logic              r_last_grant, w_last_grant_next;
    logic [ADDR_W-1:0] r_base, w_base_next;
    logic [23:0]       r_shift, w_shift_next;   // first three bytes of the word
    logic [31:0]       r_instr, w_instr_next;
    logic              r_err, w_err_next;

    logic              w_fetch_win;
    logic              w_ld_win;
    logic              w_fault;

    // Anything above the memory range, or a misaligned address when checking.
    assign w_fault = ((bus.fetch_addr >> ADDR_W) != 32'd0) ||
                     (ALIGN_CHECK && (bus.fetch_addr[1:0] != 2'b00));

    // Round-robin only matters when both ask at once: the side that did not
    // win last time goes first.
    always_comb begin
        w_fetch_win = 1'b0;
        w_ld_win    = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.fetch_req && bus.ld_req) begin
                w_ld_win    = (r_last_grant == GRANT_FETCH);
                w_fetch_win = (r_last_grant == GRANT_LOAD);
            end else begin
                w_fetch_win = bus.fetch_req;
                w_ld_win    = bus.ld_req;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_last_grant_next = r_last_grant;
        w_base_next       = r_base;
        w_shift_next      = r_shift;
        w_instr_next      = r_instr;
        w_err_next        = r_err;

        bus.fetch_ready   = 1'b0;
        bus.fetch_valid   = 1'b0;
        bus.fetch_instr   = r_instr;
        bus.fetch_err     = r_err;
        bus.ld_ack        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_we        = 1'b0;
        bus.mem_wdata     = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (w_ld_win) begin
                    bus.mem_addr      = bus.ld_addr;
                    bus.mem_wdata     = bus.ld_data;
                    bus.mem_we        = 1'b1;
                    bus.ld_ack        = 1'b1;
                    w_last_grant_next = GRANT_LOAD;
                end
                if (w_fetch_win) begin
                    bus.fetch_ready   = 1'b1;
                    w_last_grant_next = GRANT_FETCH;
                    if (w_fault) begin
                        // Faulted fetches never touch the memory port.
                        w_instr_next = 32'h0;
                        w_err_next   = 1'b1;
                        w_state_next = S_RESP;
                    end else begin
                        w_base_next  = bus.fetch_addr[ADDR_W-1:0];
                        w_cnt_next   = 2'd0;
                        w_state_next = S_RD;
                    end
                end
            end
            S_RD: begin
                // Address arithmetic is ADDR_W wide, so reads wrap at the top.
                bus.mem_addr = r_base + {{(ADDR_W-2){1'b0}}, r_cnt};
                w_shift_next = {r_shift[15:0], bus.mem_rdata};
                w_cnt_next   = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_instr_next = {r_shift, bus.mem_rdata};
                    w_err_next   = 1'b0;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.fetch_valid = 1'b1;
                w_state_next    = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Nothing leaves the block while reset is asserted, including the
        // combinational write strobe and acknowledge.
        if (reset) begin
            bus.fetch_ready = 1'b0;
            bus.fetch_valid = 1'b0;
            bus.fetch_instr = 32'h0;
            bus.fetch_err   = 1'b0;
            bus.ld_ack      = 1'b0;
            bus.mem_addr    = '0;
            bus.mem_we      = 1'b0;
            bus.mem_wdata   = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_last_grant <= GRANT_FETCH;
            r_base       <= '0;
            r_shift      <= 24'h0;
            r_instr      <= 32'h0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_last_grant <= w_last_grant_next;
            r_base       <= w_base_next;
            r_shift      <= w_shift_next;
            r_instr      <= w_instr_next;
            r_err        <= w_err_next;
        end
    end
endmodule
